stream_demux: RTL and testbench



---
 rtl/stream_demux_if.sv | 27 ++
 rtl/stream_demux.sv | 79 +++++++
 tb/tb_stream_demux.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_if.sv
// rtl/stream_demux_if.sv - input handshake, per-channel outputs and error count for stream_demux
interface stream_demux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int ERR_W    = 8
);
  logic [WIDTH-1:0]          in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_valid;
  logic                      in_ready;
  logic                      mode;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic [ERR_W-1:0]          err_count;

  modport master (
    output in_data, in_sel, in_valid, mode, out_ready,
    input  in_ready, out_data, out_valid, err_count
  );

  modport slave (
    input  in_data, in_sel, in_valid, mode, out_ready,
    output in_ready, out_data, out_valid, err_count
  );
endinterface

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - registered 1-to-N stream demux with round-robin mode and invalid-select counter
module stream_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int ERR_W    = 8
) (
  input  logic           clk,
  input  logic           reset,
  stream_demux_if.slave  bus
);
  logic [SEL_W-1:0]          rr_ptr;
  logic [SEL_W-1:0]          target;
  logic                      target_ok;
  logic                      target_free;
  logic                      in_ready_c;
  logic                      accept;
  logic [CHANNELS-1:0]       free;
  logic [CHANNELS-1:0]       valid_q;
  logic [CHANNELS*WIDTH-1:0] data_q;
  logic [ERR_W-1:0]          err_q;

  // pick the destination and decide whether a beat can be taken this cycle
  always_comb begin
    target      = bus.mode ? rr_ptr : bus.in_sel;
    target_ok   = ({1'b0, target} < (SEL_W + 1)'(CHANNELS));
    free        = ~valid_q | bus.out_ready;
    target_free = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (target == SEL_W'(i)) begin
        target_free = free[i];
      end
    end
    // beats to a non-existent channel are always taken so they can be counted and dropped
    in_ready_c = ~reset & (target_ok ? target_free : 1'b1);
    accept     = bus.in_valid & in_ready_c;
  end

  // per-channel holding registers: refill wins over drain so a busy channel never bubbles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (accept && target == SEL_W'(i)) begin
          valid_q[i]                <= 1'b1;
          data_q[i*WIDTH +: WIDTH]  <= bus.in_data;
        end else if (valid_q[i] && bus.out_ready[i]) begin
          valid_q[i]                <= 1'b0;
          data_q[i*WIDTH +: WIDTH]  <= '0;
        end
      end
    end
  end

  // round-robin pointer moves only on accepts made in round-robin mode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept && bus.mode) begin
      rr_ptr <= (rr_ptr == SEL_W'(CHANNELS - 1)) ? '0 : rr_ptr + 1'b1;
    end
  end

  // saturating count of beats discarded for an out-of-range select
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else if (accept && !target_ok && err_q != '1) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.err_count = err_q;
endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - self-checking bench for stream_demux with 4- and 3-channel instances
module tb_stream_demux;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  stream_demux_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .ERR_W(8)) b4 ();
  stream_demux_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .ERR_W(8)) b3 ();

  stream_demux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .ERR_W(8)) u4 (.clk(clk), .reset(reset), .bus(b4));
  stream_demux #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .ERR_W(8)) u3 (.clk(clk), .reset(reset), .bus(b3));

  // reference model: index 0 = 4-channel instance, 1 = 3-channel instance
  int         nch [2] = '{4, 3};
  bit         mv  [2][16];
  logic [7:0] md  [2][16];
  int         mptr[2];
  int         merr[2];

  // currently driven inputs
  bit          cv[2];
  logic [7:0]  cd[2];
  bit          cm[2];
  int          cs[2];
  logic [15:0] cr[2];

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 16; c++) begin
        mv[k][c] = 1'b0;
        md[k][c] = 8'h00;
      end
      mptr[k] = 0;
      merr[k] = 0;
    end
  endtask

  function automatic bit p_ready(int k);
    int t;
    t = cm[k] ? mptr[k] : cs[k];
    if (t >= nch[k]) return 1'b1;
    return !mv[k][t] || cr[k][t];
  endfunction

  task automatic m_step(int k);
    int t;
    bit acc;
    t   = cm[k] ? mptr[k] : cs[k];
    acc = cv[k] && p_ready(k);
    for (int c = 0; c < nch[k]; c++) begin
      if (acc && t == c) begin
        mv[k][c] = 1'b1;
        md[k][c] = cd[k];
      end else if (mv[k][c] && cr[k][c]) begin
        mv[k][c] = 1'b0;
        md[k][c] = 8'h00;
      end
    end
    if (acc && cm[k]) mptr[k] = (mptr[k] + 1) % nch[k];
    if (acc && t >= nch[k] && merr[k] < 255) merr[k] = merr[k] + 1;
  endtask

  function automatic logic [127:0] e_data(int k);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < nch[k]; c++) r[c*8 +: 8] = md[k][c];
    return r;
  endfunction

  function automatic logic [15:0] e_valid(int k);
    logic [15:0] r;
    r = '0;
    for (int c = 0; c < nch[k]; c++) r[c] = mv[k][c];
    return r;
  endfunction

  function automatic logic [127:0] a_data(int k);
    return (k == 0) ? {96'b0, b4.out_data} : {104'b0, b3.out_data};
  endfunction

  function automatic logic [15:0] a_valid(int k);
    return (k == 0) ? {12'b0, b4.out_valid} : {13'b0, b3.out_valid};
  endfunction

  function automatic logic a_ready(int k);
    return (k == 0) ? b4.in_ready : b3.in_ready;
  endfunction

  function automatic logic [7:0] a_err(int k);
    return (k == 0) ? b4.err_count : b3.err_count;
  endfunction

  task automatic drive(int k, bit v, logic [7:0] d, bit m, int s, logic [15:0] r);
    cv[k] = v; cd[k] = d; cm[k] = m; cs[k] = s; cr[k] = r;
    if (k == 0) begin
      b4.in_valid = v; b4.in_data = d; b4.mode = m; b4.in_sel = 2'(s); b4.out_ready = r[3:0];
    end else begin
      b3.in_valid = v; b3.in_data = d; b3.mode = m; b3.in_sel = 2'(s); b3.out_ready = r[2:0];
    end
  endtask

  task automatic advance();
    @(posedge clk);
    m_step(0);
    m_step(1);
    #1;
  endtask

  task automatic sync_reset_pulse();
    reset = 1'b1;
    m_reset();
    advance();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    drive(0, 1'b1, 8'hFF, 1'b1, 0, 16'hF);
    drive(1, 1'b1, 8'hFF, 1'b0, 3, 16'h7);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (a_ready(k) !== 1'b0) begin errors++; $display("FAIL reset_in_ready inst%0d got %b exp 0", k, a_ready(k)); end
      checks++;
      if (a_valid(k) !== 16'h0) begin errors++; $display("FAIL reset_out_valid inst%0d got %h exp 0", k, a_valid(k)); end
      checks++;
      if (a_data(k) !== 128'h0) begin errors++; $display("FAIL reset_out_data inst%0d got %h exp 0", k, a_data(k)); end
      checks++;
      if (a_err(k) !== 8'h0) begin errors++; $display("FAIL reset_err_count inst%0d got %h exp 0", k, a_err(k)); end
    end
    drive(0, 1'b0, 8'h00, 1'b0, 0, 16'h0);
    drive(1, 1'b0, 8'h00, 1'b0, 0, 16'h0);
  endtask

  task automatic test_directed_fill();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, vals[i], 1'b0, i, 16'h0);
      #1;
      checks++;
      if (a_ready(0) !== 1'b1) begin errors++; $display("FAIL fill_in_ready beat%0d got %b exp 1", i, a_ready(0)); end
      advance();
    end
    checks++;
    if (a_valid(0) !== 16'hF || e_valid(0) !== 16'hF) begin errors++; $display("FAIL fill_out_valid got %h exp f", a_valid(0)); end
    checks++;
    if (a_data(0) !== 128'h44332211 || e_data(0) !== 128'h44332211) begin errors++; $display("FAIL fill_out_data got %h exp 44332211", a_data(0)); end
    drive(0, 1'b1, 8'h99, 1'b0, 2, 16'h0);
    #1;
    checks++;
    if (a_ready(0) !== 1'b0) begin errors++; $display("FAIL fill_full_in_ready got %b exp 0", a_ready(0)); end
    advance();
    checks++;
    if (a_data(0) !== 128'h44332211) begin errors++; $display("FAIL fill_full_no_change got %h exp 44332211", a_data(0)); end
    drive(0, 1'b0, 8'h00, 1'b0, 0, 16'hF);
    advance();
    checks++;
    if (a_valid(0) !== 16'h0) begin errors++; $display("FAIL fill_drain_all got %h exp 0", a_valid(0)); end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b1, 8'hA0 + 8'(i), 1'b0, 1, 16'h2);
      #1;
      checks++;
      if (a_ready(0) !== 1'b1) begin errors++; $display("FAIL stream_in_ready beat%0d got %b exp 1", i, a_ready(0)); end
      advance();
      checks++;
      if (a_valid(0)[1] !== 1'b1 || a_data(0)[15:8] !== 8'hA0 + 8'(i)) begin
        errors++; $display("FAIL stream_ch1 beat%0d got v=%b d=%h exp v=1 d=%h", i, a_valid(0)[1], a_data(0)[15:8], 8'hA0 + 8'(i));
      end
    end
    drive(0, 1'b0, 8'h00, 1'b0, 0, 16'hF);
    advance();
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 7; i++) begin
      drive(1, 1'b1, 8'(i + 1), 1'b1, 0, 16'h7);
      #1;
      checks++;
      if (a_ready(1) !== 1'b1) begin errors++; $display("FAIL rr_in_ready beat%0d got %b exp 1", i, a_ready(1)); end
      advance();
      checks++;
      if (a_valid(1) !== (16'h1 << (i % 3)) || a_data(1)[(i % 3)*8 +: 8] !== 8'(i + 1)) begin
        errors++; $display("FAIL rr_target beat%0d got v=%h d=%h exp ch%0d d=%h", i, a_valid(1), a_data(1), i % 3, 8'(i + 1));
      end
    end
    drive(1, 1'b0, 8'h00, 1'b0, 0, 16'h7);
    advance();
  endtask

  task automatic test_invalid_select();
    int ready_bad = 0;
    int valid_bad = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1, 1'b1, 8'($urandom), 1'b0, 3, 16'h0);
      #1;
      if (a_ready(1) !== 1'b1) ready_bad++;
      advance();
      if (a_valid(1) !== 16'h0) valid_bad++;
    end
    checks++;
    if (ready_bad != 0) begin errors++; $display("FAIL inv_in_ready low_cycles=%0d exp 0", ready_bad); end
    checks++;
    if (valid_bad != 0) begin errors++; $display("FAIL inv_out_valid set_cycles=%0d exp 0", valid_bad); end
    checks++;
    if (a_err(1) !== 8'hFF || merr[1] != 255) begin errors++; $display("FAIL inv_err_sat got %h exp ff", a_err(1)); end
    drive(1, 1'b0, 8'h00, 1'b0, 0, 16'h0);
  endtask

  task automatic test_drain_clears();
    drive(0, 1'b1, 8'h5A, 1'b0, 2, 16'h0);
    advance();
    checks++;
    if (a_valid(0) !== 16'h4 || a_data(0) !== 128'h5A0000) begin errors++; $display("FAIL drain_load got v=%h d=%h exp v=4 d=5a0000", a_valid(0), a_data(0)); end
    drive(0, 1'b0, 8'hC3, 1'b0, 2, 16'h4);
    advance();
    checks++;
    if (a_valid(0) !== 16'h0 || a_data(0) !== 128'h0) begin errors++; $display("FAIL drain_clear got v=%h d=%h exp 0 0", a_valid(0), a_data(0)); end
    drive(0, 1'b0, 8'h00, 1'b0, 0, 16'h0);
  endtask

  task automatic test_async_reset();
    sync_reset_pulse();
    drive(0, 1'b1, 8'h61, 1'b1, 0, 16'h0);
    advance();
    drive(0, 1'b1, 8'h62, 1'b1, 0, 16'h1);
    advance();
    drive(0, 1'b1, 8'h63, 1'b0, 3, 16'h0);
    advance();
    drive(0, 1'b0, 8'h00, 1'b1, 0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1'b1, 8'h70, 1'b0, 3, 16'h0);
      advance();
    end
    drive(1, 1'b0, 8'h00, 1'b1, 0, 16'h0);
    checks++;
    if (a_valid(0) !== 16'hA || e_valid(0) !== 16'hA || mptr[0] != 2) begin errors++; $display("FAIL areset_setup_valid got %h exp a", a_valid(0)); end
    checks++;
    if (a_err(1) !== 8'd5) begin errors++; $display("FAIL areset_setup_err got %0d exp 5", a_err(1)); end
    #2;
    reset = 1'b1;
    m_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (a_valid(k) !== 16'h0 || a_data(k) !== 128'h0 || a_err(k) !== 8'h0 || a_ready(k) !== 1'b0) begin
        errors++; $display("FAIL areset_immediate inst%0d got v=%h d=%h e=%h r=%b exp all 0", k, a_valid(k), a_data(k), a_err(k), a_ready(k));
      end
    end
    reset = 1'b0;
    advance();
    drive(0, 1'b1, 8'hB7, 1'b1, 0, 16'h0);
    advance();
    checks++;
    if (a_valid(0) !== 16'h1 || a_data(0) !== 128'hB7) begin errors++; $display("FAIL areset_rr_first got v=%h d=%h exp v=1 d=b7", a_valid(0), a_data(0)); end
    drive(0, 1'b0, 8'h00, 1'b0, 0, 16'hF);
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        drive(k, 1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 16'($urandom));
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (a_ready(k) !== p_ready(k)) begin errors++; $display("FAIL rand_in_ready inst%0d cyc%0d got %b exp %b", k, n, a_ready(k), p_ready(k)); end
      end
      advance();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (a_valid(k) !== e_valid(k) || a_data(k) !== e_data(k) || a_err(k) !== 8'(merr[k])) begin
          errors++; $display("FAIL rand_outputs inst%0d cyc%0d got v=%h d=%h e=%h exp v=%h d=%h e=%h", k, n, a_valid(k), a_data(k), a_err(k), e_valid(k), e_data(k), 8'(merr[k]));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    m_reset();
    drive(0, 1'b0, 8'h00, 1'b0, 0, 16'h0);
    drive(1, 1'b0, 8'h00, 1'b0, 0, 16'h0);
    advance();
    test_reset();
    advance();
    reset = 1'b0;
    #1;
    test_directed_fill();
    test_streaming();
    test_round_robin();
    test_invalid_select();
    test_drain_clears();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
